// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready load handshake.
// Optional even-parity trailer bit when PARITY_EN is defined.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x,
    output logic             x_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
    localparam bit HAS_PAR = 1'b1;
    logic par_bit;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam bit HAS_PAR = 1'b0;
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_rest;
    logic [WIDTH-1:0] shift_rest;

    assign accept = load_valid & load_ready;

    // shreg holds the bits not yet placed on x, next one at the exit end
    always_comb begin
        first_bit  = data_in[0];
        next_bit   = shreg[0];
        load_rest  = data_in >> 1;
        shift_rest = shreg >> 1;
        if (MSB_FIRST != 0) begin
            first_bit  = data_in[WIDTH-1];
            next_bit   = shreg[WIDTH-1];
            load_rest  = data_in << 1;
            shift_rest = shreg << 1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            x          <= 1'b0;
            x_valid    <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
`ifdef PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else if (accept) begin
            state      <= SHIFT;
            shreg      <= load_rest;
            cnt        <= '0;
            x          <= first_bit;
            x_valid    <= 1'b1;
            done       <= 1'b0;
            load_ready <= 1'b0;
`ifdef PARITY_EN
            par_bit    <= ^data_in;
`endif
        end else if (state == SHIFT && cnt != LAST) begin
            shreg      <= shift_rest;
            cnt        <= cnt + 1'b1;
            x          <= next_bit;
            done       <= !HAS_PAR && (cnt == PENULT);
            load_ready <= !HAS_PAR && (cnt == PENULT);
`ifdef PARITY_EN
        end else if (state == SHIFT) begin
            state      <= PAR;
            shreg      <= '0;
            cnt        <= '0;
            x          <= par_bit;
            done       <= 1'b1;
            load_ready <= 1'b1;
`endif
        end else begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            x          <= 1'b0;
            x_valid    <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed tables, corner
// sequences and randomized traffic against a bit-queue reference model.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PARITY_EN
    localparam int FL = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FL = W;
    localparam bit PAR = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         load_valid = 1'b0;
    logic         load_ready, x, x_valid, done;
    logic [W-1:0] data_l = '0;
    logic         valid_l = 1'b0;
    logic         ready_l, x_l, xv_l, done_l;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut (
        .clock(clock), .reset(reset), .data_in(data_in),
        .load_valid(load_valid), .load_ready(load_ready),
        .x(x), .x_valid(x_valid), .done(done)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .clock(clock), .reset(reset), .data_in(data_l),
        .load_valid(valid_l), .load_ready(ready_l),
        .x(x_l), .x_valid(xv_l), .done(done_l)
    );

    // each queued entry is one future output cycle of the MSB-first DUT
    typedef struct {
        logic b;
        logic last;
    } ebit_t;
    ebit_t q[$];

    typedef struct {
        logic         lv;
        logic [W-1:0] d;
        logic [3:0]   exp;
    } vec_t;
    vec_t tab[$];

    function automatic logic [3:0] model_out();
        if (q.size() == 0) return 4'b0001;
        return {q[0].b, 1'b1, q[0].last, q[0].last};
    endfunction

    task automatic push_frame(input logic [W-1:0] d);
        ebit_t e;
        for (int i = 0; i < W; i++) begin
            e.b = d[W-1-i];
            e.last = (i == W - 1) && !PAR;
            q.push_back(e);
        end
        if (PAR) begin
            e.b = ^d;
            e.last = 1'b1;
            q.push_back(e);
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // outputs {x,x_valid,done,load_ready} are sampled on the falling edge
    task automatic step(input logic lv, input logic [W-1:0] d,
                        output logic [3:0] seen);
        bit rdy;
        @(negedge clock);
        load_valid = lv;
        data_in = d;
        seen = {x, x_valid, done, load_ready};
        check("model", {28'd0, seen}, {28'd0, model_out()});
        rdy = (q.size() <= 1);
        @(posedge clock);
        if (q.size() > 0) void'(q.pop_front());
        if (lv && rdy) push_frame(d);
    endtask

    logic [3:0]      s;
    logic [2*FL-1:0] b2b;
    logic [2*FL-1:0] b2b_exp;
    logic [7:0]      clean;
    logic            allv;

    initial begin
        @(negedge clock);
        check("reset_msb", {28'd0, x, x_valid, done, load_ready}, 32'h1);
        check("reset_lsb", {28'd0, x_l, xv_l, done_l, ready_l}, 32'h1);
        reset = 1'b0;

        // single word 8'hA5
        tab.push_back('{1'b1, 8'hA5, 4'b0001});
        tab.push_back('{1'b0, 8'h00, 4'b1100});
        tab.push_back('{1'b0, 8'h00, 4'b0100});
        tab.push_back('{1'b0, 8'h00, 4'b1100});
        tab.push_back('{1'b0, 8'h00, 4'b0100});
        tab.push_back('{1'b0, 8'h00, 4'b0100});
        tab.push_back('{1'b0, 8'h00, 4'b1100});
        tab.push_back('{1'b0, 8'h00, 4'b0100});
`ifdef PARITY_EN
        tab.push_back('{1'b0, 8'h00, 4'b1100});
        tab.push_back('{1'b0, 8'h00, 4'b0111});
`else
        tab.push_back('{1'b0, 8'h00, 4'b1111});
`endif
        tab.push_back('{1'b0, 8'h00, 4'b0001});
        foreach (tab[i]) begin
            step(tab[i].lv, tab[i].d, s);
            check("tab_a5", {28'd0, s}, {28'd0, tab[i].exp});
        end

        // back-to-back 0A then 05 accepted in the final-bit cycle
`ifdef PARITY_EN
        b2b_exp = 18'b000010100_000001010;
`else
        b2b_exp = 16'b0000101000000101;
`endif
        step(1'b1, 8'h0A, s);
        allv = 1'b1;
        for (int k = 1; k <= 2 * FL; k++) begin
            step(k == FL, 8'h05, s);
            b2b[2*FL-k] = s[3];
            allv &= s[2];
        end
        check("b2b_bits", 32'(b2b), 32'(b2b_exp));
        check("b2b_valid", {31'd0, allv}, 32'd1);
        step(1'b0, 8'h00, s);

        // load offered mid-frame is ignored
        step(1'b1, 8'hA5, s);
        step(1'b0, 8'h00, s);
        step(1'b0, 8'h00, s);
        step(1'b1, 8'hFF, s);
        check("ignored_ready", {31'd0, s[0]}, 32'd0);
        for (int k = 0; k < FL; k++) step(1'b0, 8'h00, s);
        check("after_ignore_idle", {28'd0, s}, 32'h1);

`ifdef PARITY_EN
        step(1'b1, 8'h07, s);
        for (int k = 1; k <= FL; k++) step(1'b0, 8'h00, s);
        check("parity_07", {30'd0, s[3], s[1]}, 32'd3);
`endif

        // reset while bit 4 of A5 is on x
        step(1'b1, 8'hA5, s);
        for (int k = 0; k < 3; k++) step(1'b0, 8'h00, s);
        @(negedge clock);
        check("pre_reset_bit4", {28'd0, x, x_valid, done, load_ready}, 32'h4);
        reset = 1'b1;
        #1;
        check("async_reset", {28'd0, x, x_valid, done, load_ready}, 32'h1);
        q.delete();
        @(negedge clock);
        reset = 1'b0;
        step(1'b1, 8'h3C, s);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 8'h00, s);
            clean[8-k] = s[3];
        end
        check("post_reset_3c", {24'd0, clean}, 32'h3C);
        for (int k = 8; k < FL; k++) step(1'b0, 8'h00, s);

        // LSB-first instance
        @(negedge clock);
        valid_l = 1'b1;
        data_l = 8'h01;
        @(negedge clock);
        valid_l = 1'b0;
        data_l = 8'hFF;
        check("lsb_bit1", {30'd0, x_l, xv_l}, 32'd3);
        for (int k = 2; k <= 8; k++) begin
            @(negedge clock);
            check("lsb_bitn", {30'd0, x_l, xv_l}, 32'd1);
        end

        // randomized traffic against the queue model
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 2) != 0, W'($urandom), s);
        end
        for (int k = 0; k < FL + 1; k++) step(1'b0, 8'h00, s);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
